// File: rtl/load_store_unit.sv
// RV32I load/store front end for a word-wide RAM with 1-cycle synchronous read.
// Sub-word stores use read-modify-write. Bad accesses fault without touching the RAM.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              CLOCK,
  input  logic              RST,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  output logic              ram_wr_en,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_MRG,
    S_WR,
    S_ERR
  } state_t;

  state_t state, next_state;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        req_bad;
  logic        accept;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_result;
  logic [31:0] merged;

  // Byte-address bits above the RAM window wrap, so they are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  assign accept = (state == S_IDLE) && req;

  always_comb begin
    req_bad = 1'b0;
    case (funct3)
      F3_B:    req_bad = 1'b0;
      F3_H:    req_bad = addr[0];
      F3_W:    req_bad = (addr[1:0] != 2'b00);
      F3_BU:   req_bad = we;
      F3_HU:   req_bad = we | addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (req_bad)
            next_state = S_ERR;
          else if (we && (funct3 == F3_W))
            next_state = S_WR;
          else
            next_state = S_RD;
        end
      end
      S_RD:    next_state = we_q ? S_MRG : S_CAP;
      S_CAP:   next_state = S_IDLE;
      S_MRG:   next_state = S_IDLE;
      S_WR:    next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    load_byte = ram_dout[7:0];
    case (addr_q[1:0])
      2'd0: load_byte = ram_dout[7:0];
      2'd1: load_byte = ram_dout[15:8];
      2'd2: load_byte = ram_dout[23:16];
      2'd3: load_byte = ram_dout[31:24];
      default: load_byte = ram_dout[7:0];
    endcase
    load_half = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];

    load_result = ram_dout;
    case (funct3_q)
      F3_B:    load_result = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_result = {{16{load_half[15]}}, load_half};
      F3_BU:   load_result = {24'h0, load_byte};
      F3_HU:   load_result = {16'h0, load_half};
      default: load_result = ram_dout;
    endcase
  end

  always_comb begin
    merged = ram_dout;
    if (funct3_q == F3_H) begin
      if (addr_q[1])
        merged[31:16] = wdata_q[15:0];
      else
        merged[15:0] = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = ram_dout;
      endcase
    end
  end

  // Enables are gated by reset so an access aborted by RST never writes the RAM.
  assign busy      = (state != S_IDLE);
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_rd_en = (state == S_RD) && !RST;
  assign ram_wr_en = ((state == S_MRG) || (state == S_WR)) && !RST;

  always_comb begin
    ram_din = 32'h0;
    if (ram_wr_en)
      ram_din = (state == S_WR) ? wdata_q : merged;
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      fault    <= 1'b0;
      rdata    <= 32'h0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      fault <= 1'b0;
      if (accept) begin
        we_q     <= we;
        funct3_q <= funct3;
        addr_q   <= addr[ADDR_W+1:0];
        wdata_q  <= wdata;
      end
      case (state)
        S_CAP: begin
          rdata <= load_result;
          done  <= 1'b1;
        end
        S_MRG, S_WR: done <= 1'b1;
        S_ERR: begin
          done  <= 1'b1;
          fault <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: RAM model, scoreboard of expected
// completions, and one task per scenario.
module tb_load_store_unit;

  logic        CLOCK = 1'b0;
  logic        RST = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic [9:0]  ram_addr;
  logic        ram_rd_en, ram_wr_en;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_rdata = 32'h0;

  int          obs_lat, obs_rd_cnt, obs_wr_cnt, obs_rd_cycle, obs_wr_cycle;
  logic [9:0]  obs_rd_addr, obs_wr_addr;
  logic [31:0] obs_din, obs_rdata;
  logic        obs_fault;

  load_store_unit #(.ADDR_W(10)) dut (
    .CLOCK(CLOCK), .RST(RST), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) begin
    if (ram_rd_en) ram_dout <= mem[ram_addr];
    if (ram_wr_en) mem[ram_addr] <= ram_din;
  end

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    s = w >> (32'(off) * 8);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return s & 32'h0000_00FF;
      3'b101:  return s & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3 == 3'b000) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask = mask << (32'(off) * 8);
    return (w & ~mask) | ((wd << (32'(off) * 8)) & mask);
  endfunction

  // Drives one request and observes the access until done, bounded to 8 cycles.
  task automatic do_access(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    @(negedge CLOCK);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge CLOCK);
    #1 req = 1'b0;
    obs_lat = -1; obs_rd_cnt = 0; obs_wr_cnt = 0; obs_rd_cycle = -1; obs_wr_cycle = -1;
    obs_rd_addr = '0; obs_wr_addr = '0; obs_din = '0; obs_rdata = '0; obs_fault = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLOCK);
      if (ram_rd_en) begin
        obs_rd_cnt++;
        if (obs_rd_cycle < 0) obs_rd_cycle = c;
        obs_rd_addr = ram_addr;
      end
      if (ram_wr_en) begin
        obs_wr_cnt++;
        if (obs_wr_cycle < 0) obs_wr_cycle = c;
        obs_wr_addr = ram_addr;
        obs_din = ram_din;
      end
      if (done) begin
        obs_lat = c;
        obs_rdata = rdata;
        obs_fault = fault;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLOCK);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if ({ram_rd_en, ram_wr_en} !== 2'b00) $display("FAIL reset_en got %b want 00", {ram_rd_en, ram_wr_en}); else pass_cnt++;
    RST = 1'b0;
  endtask

  task automatic test_load_word();
    exp_t e;
    mem[4] = 32'h8899_AABB;
    e.rdata = 32'h8899_AABB; e.fault = 1'b0; e.lat = 3;
    sb_q.push_back(e);
    do_access(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    e = sb_q.pop_front();
    last_rdata = e.rdata;
    total_cnt++; if (obs_rd_cycle !== 1) $display("FAIL lw_rd_cycle got %0d want 1", obs_rd_cycle); else pass_cnt++;
    total_cnt++; if (obs_rd_addr !== 10'd4) $display("FAIL lw_ram_addr got %0d want 4", obs_rd_addr); else pass_cnt++;
    total_cnt++; if (obs_lat !== e.lat) $display("FAIL lw_latency got %0d want %0d", obs_lat, e.lat); else pass_cnt++;
    total_cnt++; if (obs_rdata !== e.rdata) $display("FAIL lw_rdata got %h want %h", obs_rdata, e.rdata); else pass_cnt++;
    total_cnt++; if (obs_fault !== e.fault) $display("FAIL lw_fault got %b want %b", obs_fault, e.fault); else pass_cnt++;
    @(negedge CLOCK);
    total_cnt++; if ({done, busy} !== 2'b00) $display("FAIL lw_done_pulse got %b want 00", {done, busy}); else pass_cnt++;
  endtask

  task automatic test_load_subword();
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100};
    logic [31:0] adrs [6] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h11};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.rdata = model_load(mem[4], f3s[i], adrs[i][1:0]); e.fault = 1'b0; e.lat = 3;
      sb_q.push_back(e);
      do_access(1'b0, f3s[i], adrs[i], 32'h0);
      e = sb_q.pop_front();
      last_rdata = e.rdata;
      total_cnt++; if (obs_rdata !== e.rdata) $display("FAIL subload_%0d rdata got %h want %h", i, obs_rdata, e.rdata); else pass_cnt++;
      total_cnt++; if (obs_lat !== e.lat || obs_fault !== e.fault) $display("FAIL subload_%0d lat/fault got %0d/%b want %0d/%b", i, obs_lat, obs_fault, e.lat, e.fault); else pass_cnt++;
    end
    // Constants straight from the datasheet example word 0x8899_AABB.
    do_access(1'b0, 3'b000, 32'h13, 32'h0);
    total_cnt++; if (obs_rdata !== 32'hFFFF_FF88) $display("FAIL lb_const got %h want ffffff88", obs_rdata); else pass_cnt++;
    do_access(1'b0, 3'b001, 32'h12, 32'h0);
    total_cnt++; if (obs_rdata !== 32'hFFFF_8899) $display("FAIL lh_const got %h want ffff8899", obs_rdata); else pass_cnt++;
    last_rdata = 32'hFFFF_8899;
  endtask

  task automatic test_store_sub();
    exp_t e;
    logic [31:0] want;
    want = model_merge(mem[4], 3'b000, 2'd1, 32'h0000_0055);
    e.rdata = last_rdata; e.fault = 1'b0; e.lat = 3;
    sb_q.push_back(e);
    do_access(1'b1, 3'b000, 32'h11, 32'h0000_0055);
    e = sb_q.pop_front();
    total_cnt++; if (obs_wr_cnt !== 1) $display("FAIL sb_wr_count got %0d want 1", obs_wr_cnt); else pass_cnt++;
    total_cnt++; if (obs_din !== 32'h8899_55BB || want !== 32'h8899_55BB) $display("FAIL sb_din got %h want 889955bb", obs_din); else pass_cnt++;
    total_cnt++; if (obs_lat !== e.lat) $display("FAIL sb_latency got %0d want %0d", obs_lat, e.lat); else pass_cnt++;
    total_cnt++; if (obs_rdata !== e.rdata) $display("FAIL sb_rdata_held got %h want %h", obs_rdata, e.rdata); else pass_cnt++;
    do_access(1'b0, 3'b010, 32'h10, 32'h0);
    total_cnt++; if (obs_rdata !== 32'h8899_55BB) $display("FAIL sb_readback got %h want 889955bb", obs_rdata); else pass_cnt++;
    want = model_merge(32'h8899_55BB, 3'b001, 2'd2, 32'hABCD_1234);
    do_access(1'b1, 3'b001, 32'h12, 32'hABCD_1234);
    total_cnt++; if (mem[4] !== want) $display("FAIL sh_mem got %h want %h", mem[4], want); else pass_cnt++;
    last_rdata = 32'h8899_55BB;
  endtask

  task automatic test_store_word_and_faults();
    exp_t e;
    logic        fw  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ff3 [4] = '{3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] fad [4] = '{32'h21, 32'h20, 32'h20, 32'h22};
    e.rdata = last_rdata; e.fault = 1'b0; e.lat = 2;
    sb_q.push_back(e);
    do_access(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    e = sb_q.pop_front();
    total_cnt++; if (obs_wr_cycle !== 1 || obs_wr_addr !== 10'd8) $display("FAIL sw_wr got cycle %0d addr %0d want 1/8", obs_wr_cycle, obs_wr_addr); else pass_cnt++;
    total_cnt++; if (obs_lat !== e.lat || obs_rd_cnt !== 0) $display("FAIL sw_lat got %0d rd %0d want %0d/0", obs_lat, obs_rd_cnt, e.lat); else pass_cnt++;
    total_cnt++; if (mem[8] !== 32'hDEAD_BEEF) $display("FAIL sw_mem got %h want deadbeef", mem[8]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      e.rdata = last_rdata; e.fault = 1'b1; e.lat = 2;
      sb_q.push_back(e);
      do_access(fw[i], ff3[i], fad[i], 32'h1111_1111);
      e = sb_q.pop_front();
      total_cnt++; if (obs_fault !== e.fault || obs_lat !== e.lat) $display("FAIL fault_%0d got fault %b lat %0d want %b/%0d", i, obs_fault, obs_lat, e.fault, e.lat); else pass_cnt++;
      total_cnt++; if (obs_rd_cnt !== 0 || obs_wr_cnt !== 0) $display("FAIL fault_%0d_en got rd %0d wr %0d want 0/0", i, obs_rd_cnt, obs_wr_cnt); else pass_cnt++;
      total_cnt++; if (obs_rdata !== e.rdata) $display("FAIL fault_%0d_rdata got %h want %h", i, obs_rdata, e.rdata); else pass_cnt++;
    end
    total_cnt++; if (mem[8] !== 32'hDEAD_BEEF) $display("FAIL fault_no_write got %h want deadbeef", mem[8]); else pass_cnt++;
    do_access(1'b0, 3'b010, 32'h0000_1020, 32'h0);
    total_cnt++; if (obs_rd_addr !== 10'd8 || obs_rdata !== 32'hDEAD_BEEF) $display("FAIL wrap got addr %0d data %h want 8/deadbeef", obs_rd_addr, obs_rdata); else pass_cnt++;
    last_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    e.rdata = 32'hDEAD_BEEF; e.fault = 1'b0; e.lat = 3;
    sb_q.push_back(e);
    @(negedge CLOCK);
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h20; wdata = 32'h0;
    @(posedge CLOCK);
    #1 req = 1'b0;
    @(negedge CLOCK);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h0BAD_0BAD;
    @(negedge CLOCK);
    req = 1'b0;
    @(negedge CLOCK);
    e = sb_q.pop_front();
    total_cnt++; if (done !== 1'b1 || rdata !== e.rdata) $display("FAIL b2b_load got done %b rdata %h want 1/%h", done, rdata, e.rdata); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle_busy got %b want 0", busy); else pass_cnt++;
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h24; wdata = 32'hCAFE_F00D;
    @(posedge CLOCK);
    #1 req = 1'b0;
    @(negedge CLOCK);
    total_cnt++; if (busy !== 1'b1 || ram_wr_en !== 1'b1 || ram_addr !== 10'd9) $display("FAIL b2b_store got busy %b wr %b addr %0d want 1/1/9", busy, ram_wr_en, ram_addr); else pass_cnt++;
    @(negedge CLOCK);
    total_cnt++; if (done !== 1'b1 || fault !== 1'b0) $display("FAIL b2b_store_done got %b%b want 10", done, fault); else pass_cnt++;
    total_cnt++; if (mem[9] !== 32'hCAFE_F00D) $display("FAIL b2b_mem9 got %h want cafef00d", mem[9]); else pass_cnt++;
    total_cnt++; if (mem[8] !== 32'hDEAD_BEEF) $display("FAIL busy_req_ignored got %h want deadbeef", mem[8]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int extra_done;
    mem[5] = 32'h1122_3344;
    @(negedge CLOCK);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h14; wdata = 32'h0000_00AA;
    @(posedge CLOCK);
    #1 req = 1'b0;
    @(negedge CLOCK);
    @(negedge CLOCK);
    total_cnt++; if (ram_wr_en !== 1'b1) $display("FAIL mrg_reached got wr %b want 1", ram_wr_en); else pass_cnt++;
    RST = 1'b1;
    #1;
    total_cnt++; if (ram_wr_en !== 1'b0 || ram_din !== 32'h0) $display("FAIL rst_gate got wr %b din %h want 0/0", ram_wr_en, ram_din); else pass_cnt++;
    @(negedge CLOCK);
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_abort got busy %b done %b want 0/0", busy, done); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else pass_cnt++;
    RST = 1'b0;
    extra_done = 0;
    repeat (3) begin
      @(negedge CLOCK);
      if (done) extra_done++;
    end
    total_cnt++; if (extra_done !== 0) $display("FAIL rst_no_done got %0d want 0", extra_done); else pass_cnt++;
    total_cnt++; if (mem[5] !== 32'h1122_3344) $display("FAIL rst_mem got %h want 11223344", mem[5]); else pass_cnt++;
    do_access(1'b0, 3'b101, 32'h16, 32'h0);
    total_cnt++; if (obs_rdata !== 32'h0000_1122 || obs_lat !== 3) $display("FAIL post_rst_lhu got %h lat %0d want 00001122/3", obs_rdata, obs_lat); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_load_word();
    test_load_subword();
    test_store_sub();
    test_store_word_and_faults();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
